// File: rtl/apb_fsm_controller_if.sv
// Bundle between the AHB slave interface and the APB sequencer:
// pipelined AHB-side qualifiers in, APB phase signals and ready out.
interface apb_fsm_controller_if #(
    parameter int ADDR_W = 32
);
    logic              valid;
    logic              Hwrite;
    logic              Hwritereg;
    logic [ADDR_W-1:0] Haddr;
    logic [ADDR_W-1:0] Haddr1;
    logic [ADDR_W-1:0] Haddr2;
    logic [ADDR_W-1:0] Hwdata;
    logic [ADDR_W-1:0] Hwdata1;
    logic [2:0]        Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [ADDR_W-1:0] Paddr;
    logic [ADDR_W-1:0] Pwdata;
    logic              Hreadyout;

    modport master (
        output valid, Hwrite, Hwritereg,
        output Haddr, Haddr1, Haddr2,
        output Hwdata, Hwdata1,
        input  Pselx, Penable, Pwrite,
        input  Paddr, Pwdata, Hreadyout
    );

    modport slave (
        input  valid, Hwrite, Hwritereg,
        input  Haddr, Haddr1, Haddr2,
        input  Hwdata, Hwdata1,
        output Pselx, Penable, Pwrite,
        output Paddr, Pwdata, Hreadyout
    );
endinterface

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB2APB bridge: turns qualified AHB
// transfers into APB setup/enable phases with fully registered outputs.
module apb_fsm_controller #(
    parameter int              ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE0 = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] BASE1 = 32'h8400_0000,
    parameter logic [ADDR_W-1:0] BASE2 = 32'h8800_0000
) (
    input  logic                 Hclk,
    input  logic                 Hreset,
    apb_fsm_controller_if.slave  bus
);
    localparam int WIN = 26;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RENABLE,
        WWAIT,
        WRITE,
        WENABLE,
        WRITEP,
        WENABLEP
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        psel_q, psel_d;
    logic              pen_q, pen_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [ADDR_W-1:0] pwdata_q, pwdata_d;
    logic              hrdy_q, hrdy_d;

    function automatic logic [2:0] decode(
        input logic [ADDR_W-1:0] a
    );
        logic [2:0] s;
        s = 3'b000;
        if (a[ADDR_W-1:WIN] == BASE0[ADDR_W-1:WIN])
            s = 3'b001;
        else if (a[ADDR_W-1:WIN] == BASE1[ADDR_W-1:WIN])
            s = 3'b010;
        else if (a[ADDR_W-1:WIN] == BASE2[ADDR_W-1:WIN])
            s = 3'b100;
        return s;
    endfunction

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q  <= IDLE;
            psel_q   <= 3'b000;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            hrdy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            psel_q   <= psel_d;
            pen_q    <= pen_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            hrdy_q   <= hrdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RENABLE, WENABLE: begin
                if (bus.valid)
                    state_d = bus.Hwrite ? WWAIT : READ;
                else
                    state_d = IDLE;
            end
            READ:    state_d = RENABLE;
            WWAIT:   state_d = bus.valid ? WRITEP : WRITE;
            WRITE:   state_d = WENABLE;
            WRITEP:  state_d = WENABLEP;
            WENABLEP: begin
                if (!bus.Hwritereg)
                    state_d = READ;
                else if (bus.valid)
                    state_d = WRITEP;
                else
                    state_d = WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are loaded for the state being entered, so the
    // setup values are already stable on the bus during setup.
    always_comb begin
        psel_d   = psel_q;
        pen_d    = 1'b0;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        hrdy_d   = 1'b1;
        unique case (state_d)
            IDLE, WWAIT: begin
                psel_d = 3'b000;
            end
            READ: begin
                paddr_d  = bus.Haddr;
                psel_d   = decode(bus.Haddr);
                pwrite_d = 1'b0;
                hrdy_d   = 1'b0;
            end
            WRITE: begin
                paddr_d  = bus.Haddr1;
                pwdata_d = bus.Hwdata;
                psel_d   = decode(bus.Haddr1);
                pwrite_d = 1'b1;
                hrdy_d   = 1'b0;
            end
            WRITEP: begin
                paddr_d  = bus.Haddr2;
                pwdata_d = bus.Hwdata1;
                psel_d   = decode(bus.Haddr2);
                pwrite_d = 1'b1;
                hrdy_d   = 1'b0;
            end
            RENABLE, WENABLE: begin
                pen_d = 1'b1;
            end
            WENABLEP: begin
                pen_d  = 1'b1;
                hrdy_d = 1'b0;
            end
            default: begin
                psel_d = 3'b000;
            end
        endcase
    end

    assign bus.Pselx     = psel_q;
    assign bus.Penable   = pen_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Hreadyout = hrdy_q;
endmodule
